// File: rtl/axi_rd_master.sv
// axi_rd_master: single-burst AXI4 read initiator with RLAST/RRESP checking
module axi_rd_master #(
  parameter int ADDR_WIDTH = 26,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  init_end,
  input  logic                  rd_trig,
  input  logic [7:0]            rd_len,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic                  rd_ready,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_data_valid,
  input  logic                  rd_data_ready,
  output logic                  rd_done,
  output logic [2:0]            rd_err,
  output logic                  axi_arvalid,
  input  logic                  axi_arready,
  output logic [ADDR_WIDTH-1:0] axi_araddr,
  output logic [7:0]            axi_arlen,
  input  logic                  axi_rvalid,
  output logic                  axi_rready,
  input  logic [DATA_WIDTH-1:0] axi_rdata,
  input  logic                  axi_rlast,
  input  logic [1:0]            axi_rresp
);
  typedef enum logic [2:0] {IDLE, AR, R, DRAIN, DONE} state_t;
  state_t                state_q, state_d;
  logic [7:0]            cnt_q, cnt_d;
  logic                  arvalid_q, arvalid_d;
  logic [ADDR_WIDTH-1:0] araddr_q, araddr_d;
  logic [7:0]            arlen_q, arlen_d;
  logic [2:0]            err_q, err_d;
  logic                  beat;
  assign rd_ready      = (state_q == IDLE) && init_end;
  assign rd_done       = (state_q == DONE);
  assign rd_err        = err_q;
  assign rd_data       = axi_rdata;
  assign rd_data_valid = (state_q == R) && axi_rvalid;
  assign axi_rready    = (state_q == R) ? rd_data_ready : (state_q == DRAIN);
  assign axi_arvalid   = arvalid_q;
  assign axi_araddr    = araddr_q;
  assign axi_arlen     = arlen_q;
  assign beat          = axi_rvalid && axi_rready;
  // State and AR/status registers; reset abandons any burst in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      arvalid_q <= 1'b0;
      araddr_q  <= '0;
      arlen_q   <= '0;
      err_q     <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      arvalid_q <= arvalid_d;
      araddr_q  <= araddr_d;
      arlen_q   <= arlen_d;
      err_q     <= err_d;
    end
  end
  // Burst sequencing: count beats down to 0 and classify RLAST/RRESP anomalies
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    arvalid_d = arvalid_q;
    araddr_d  = araddr_q;
    arlen_d   = arlen_q;
    err_d     = err_q;
    case (state_q)
      IDLE: if (rd_trig && init_end) begin
        araddr_d  = rd_addr;
        arlen_d   = rd_len;
        arvalid_d = 1'b1;
        cnt_d     = rd_len;
        err_d     = '0;
        state_d   = AR;
      end
      AR: if (arvalid_q && axi_arready) begin
        arvalid_d = 1'b0;
        state_d   = R;
      end
      R: if (beat) begin
        err_d[0] = err_q[0] | (axi_rresp != 2'b00);
        if (axi_rlast && cnt_q != 8'd0) begin
          err_d[1] = 1'b1;
          state_d  = DONE;
        end else if (cnt_q == 8'd0) begin
          err_d[2] = err_q[2] | ~axi_rlast;
          state_d  = axi_rlast ? DONE : DRAIN;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      DRAIN: if (beat) begin
        err_d[0] = err_q[0] | (axi_rresp != 2'b00);
        state_d  = axi_rlast ? DONE : DRAIN;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
endmodule

// File: tb/tb_axi_rd_master.sv
// tb_axi_rd_master: scoreboard bench for the AXI read initiator
module tb_axi_rd_master;
  logic        clk = 1'b0;
  logic        rst, init_end, rd_trig, rd_data_ready;
  logic [7:0]  rd_len;
  logic [25:0] rd_addr;
  logic        rd_ready, rd_data_valid, rd_done;
  logic [31:0] rd_data;
  logic [2:0]  rd_err;
  logic        axi_arvalid, axi_arready, axi_rvalid, axi_rready, axi_rlast;
  logic [25:0] axi_araddr;
  logic [7:0]  axi_arlen;
  logic [31:0] axi_rdata;
  logic [1:0]  axi_rresp;
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  logic [31:0] sb[$];
  always #5 clk = ~clk;
  axi_rd_master #(.ADDR_WIDTH(26), .DATA_WIDTH(32)) dut (
    .clk(clk), .rst(rst), .init_end(init_end), .rd_trig(rd_trig),
    .rd_len(rd_len), .rd_addr(rd_addr), .rd_ready(rd_ready),
    .rd_data(rd_data), .rd_data_valid(rd_data_valid),
    .rd_data_ready(rd_data_ready), .rd_done(rd_done), .rd_err(rd_err),
    .axi_arvalid(axi_arvalid), .axi_arready(axi_arready),
    .axi_araddr(axi_araddr), .axi_arlen(axi_arlen),
    .axi_rvalid(axi_rvalid), .axi_rready(axi_rready),
    .axi_rdata(axi_rdata), .axi_rlast(axi_rlast), .axi_rresp(axi_rresp)
  );
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask
  // Every beat handed to the client must match the head of the scoreboard
  always @(negedge clk)
    if (!rst && rd_data_valid && rd_data_ready) begin
      if (sb.size() == 0) check("unexpected_beat", 1, 0);
      else check("rd_data", rd_data, sb.pop_front());
    end
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic start(input logic [25:0] addr, input logic [7:0] len);
    rd_trig = 1'b1;
    rd_addr = addr;
    rd_len  = len;
    @(negedge clk);
    check("rd_ready_idle", rd_ready, 1);
    step();
    rd_trig = 1'b0;
    rd_addr = 26'h3ffffff;
    rd_len  = 8'hff;
    @(negedge clk);
    check("arvalid_rise", axi_arvalid, 1);
    check("araddr", axi_araddr, addr);
    check("arlen", axi_arlen, len);
    check("rd_ready_busy", rd_ready, 0);
  endtask
  task automatic ar_phase(input int d, input logic [25:0] addr);
    repeat (d) begin
      step();
      @(negedge clk);
      check("arvalid_hold", axi_arvalid, 1);
      check("araddr_hold", axi_araddr, addr);
    end
    step();
    axi_arready = 1'b1;
    @(negedge clk);
    check("arvalid_hs", axi_arvalid, 1);
    step();
    axi_arready = 1'b0;
  endtask
  task automatic burst(input logic [25:0] addr, input logic [7:0] len, input int ard,
                       input int nb, input int erri, input bit toggle, input logic [2:0] exp_err);
    logic [31:0] data;
    bit acc, first;
    int t;
    start(addr, len);
    ar_phase(ard, addr);
    first = 1'b1;
    for (int i = 0; i < nb; i++) begin
      data = (nb == 1) ? 32'hA5A5A5A5 : $urandom;
      if (i <= int'(len)) sb.push_back(data);
      axi_rvalid = 1'b1;
      axi_rdata  = data;
      axi_rlast  = (i == nb - 1);
      axi_rresp  = (i == erri) ? 2'b10 : 2'b00;
      acc = 1'b0;
      t = 0;
      while (!acc && t < 50) begin
        rd_data_ready = toggle ? cyc[0] : 1'b1;
        cyc++;
        t++;
        @(negedge clk);
        if (first) check("arvalid_drop", axi_arvalid, 0);
        first = 1'b0;
        acc = axi_rvalid && axi_rready;
        check("rd_data_valid", rd_data_valid, i <= int'(len));
        check("axi_rready", axi_rready, (i <= int'(len)) ? rd_data_ready : 1'b1);
        step();
      end
      if (!acc) check("beat_timeout", 1, 0);
    end
    axi_rvalid = 1'b0;
    axi_rlast  = 1'b0;
    axi_rresp  = 2'b00;
    @(negedge clk);
    check("rd_done", rd_done, 1);
    check("rd_err", rd_err, exp_err);
    check("valid_after", rd_data_valid, 0);
    step();
    @(negedge clk);
    check("rd_done_pulse", rd_done, 0);
    check("rd_ready_back", rd_ready, 1);
    check("rd_err_held", rd_err, exp_err);
    check("sb_empty", sb.size(), 0);
    sb.delete();
    step();
  endtask
  initial begin
    rst = 1'b1; init_end = 1'b0; rd_trig = 1'b0; rd_len = '0; rd_addr = '0;
    rd_data_ready = 1'b0; axi_arready = 1'b0; axi_rvalid = 1'b0;
    axi_rdata = '0; axi_rlast = 1'b0; axi_rresp = 2'b00;
    step();
    step();
    @(negedge clk);
    check("rst_arvalid", axi_arvalid, 0);
    check("rst_araddr", axi_araddr, 0);
    check("rst_arlen", axi_arlen, 0);
    check("rst_err", rd_err, 0);
    check("rst_done", rd_done, 0);
    check("rst_rready", axi_rready, 0);
    rst = 1'b0;
    step();
    rd_trig = 1'b1;
    rd_addr = 26'h40;
    repeat (3) begin
      @(negedge clk);
      check("gate_rd_ready", rd_ready, 0);
      step();
      @(negedge clk);
      check("gate_arvalid", axi_arvalid, 0);
    end
    rd_trig = 1'b0;
    init_end = 1'b1;
    step();
    burst(26'h100, 8'd0, 0, 1, -1, 1'b0, 3'b000);
    burst(26'h2000, 8'd7, 3, 8, -1, 1'b1, 3'b000);
    burst(26'h3004, 8'd3, 0, 4, 2, 1'b0, 3'b001);
    burst(26'h0ff0, 8'd7, 1, 4, -1, 1'b0, 3'b010);
    burst(26'h1230, 8'd1, 0, 3, -1, 1'b1, 3'b100);
    burst(26'h3ffff00, 8'd255, 0, 256, 200, 1'b0, 3'b001);
    start(26'h500, 8'd15);
    ar_phase(0, 26'h500);
    rd_data_ready = 1'b1;
    axi_rvalid = 1'b1;
    axi_rdata  = 32'h11223344;
    axi_rresp  = 2'b10;
    sb.push_back(32'h11223344);
    @(negedge clk);
    check("pre_rst_rready", axi_rready, 1);
    step();
    axi_rvalid = 1'b0;
    axi_rresp  = 2'b00;
    @(negedge clk);
    check("pre_rst_err", rd_err, 3'b001);
    check("pre_rst_sb", sb.size(), 0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    @(negedge clk);
    check("mid_rst_arvalid", axi_arvalid, 0);
    check("mid_rst_rready", axi_rready, 0);
    check("mid_rst_err", rd_err, 0);
    check("mid_rst_rd_ready", rd_ready, 1);
    check("mid_rst_araddr", axi_araddr, 0);
    step();
    burst(26'h600, 8'd2, 0, 3, -1, 1'b0, 3'b000);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
  initial begin
    #2000000;
    $display("FAIL global_timeout got 1 expected 0");
    $fatal(1, "timeout");
  end
endmodule
